// File: rtl/ti_reg_ctrl_if.sv
// CPU write port and decoded configuration outputs of the PSG register controller.
// The CPU side drives wr_valid/wr_data; the controller drives everything else.
interface ti_reg_ctrl_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [9:0] tone0;
  logic [9:0] tone1;
  logic [9:0] tone2;
  logic [2:0] noise_ctrl;
  logic       noise_rst;
  logic [3:0] vol0;
  logic [3:0] vol1;
  logic [3:0] vol2;
  logic [3:0] vol3;

  modport master (
    output wr_valid, wr_data,
    input  wr_ready, tone0, tone1, tone2, noise_ctrl, noise_rst,
           vol0, vol1, vol2, vol3
  );

  modport slave (
    input  wr_valid, wr_data,
    output wr_ready, tone0, tone1, tone2, noise_ctrl, noise_rst,
           vol0, vol1, vol2, vol3
  );
endinterface

// File: rtl/ti_reg_ctrl.sv
// Register-write controller for an SN76489-style PSG.
// Decodes latch/data bytes into tone, noise and volume registers and stalls
// the CPU for WAIT_CYCLES cycles after every accepted byte.
module ti_reg_ctrl #(
  parameter int WAIT_CYCLES = 32,
  localparam int BUSY_W = $clog2(WAIT_CYCLES + 1)
) (
  input logic           CLK,
  input logic           nRST,
  ti_reg_ctrl_if.slave  bus
);

  // A zero-length busy window still needs a legal one-bit counter.
  localparam int CNT_W = (BUSY_W < 1) ? 1 : BUSY_W;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       latchCh_q, latchCh_d;
  logic             latchType_q, latchType_d;
  logic [9:0]       tone_q [0:2];
  logic [9:0]       tone_d [0:2];
  logic [3:0]       vol_q [0:3];
  logic [3:0]       vol_d [0:3];
  logic [2:0]       noiseCtrl_q, noiseCtrl_d;
  logic             noiseRst_q, noiseRst_d;

  logic       accept;
  logic       isLatch;
  logic [1:0] tgtCh;
  logic       tgtType;

  assign accept  = bus.wr_valid && (state_q == IDLE);
  assign isLatch = bus.wr_data[7];
  assign tgtCh   = isLatch ? bus.wr_data[6:5] : latchCh_q;
  assign tgtType = isLatch ? bus.wr_data[4]   : latchType_q;

  // Busy-window FSM: one accepted byte, then WAIT_CYCLES cycles of stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && (WAIT_CYCLES != 0)) begin
          state_d = BUSY;
          cnt_d   = WAIT_CNT;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - LAST_CNT;
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte decode: latch bytes retarget and write low bits, data bytes reuse the latch.
  always_comb begin
    latchCh_d   = latchCh_q;
    latchType_d = latchType_q;
    tone_d      = tone_q;
    vol_d       = vol_q;
    noiseCtrl_d = noiseCtrl_q;
    noiseRst_d  = 1'b0;
    if (accept) begin
      if (isLatch) begin
        latchCh_d   = bus.wr_data[6:5];
        latchType_d = bus.wr_data[4];
      end
      if (tgtType) begin
        vol_d[tgtCh] = bus.wr_data[3:0];
      end else if (tgtCh == 2'd3) begin
        noiseCtrl_d = bus.wr_data[2:0];
        noiseRst_d  = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (tgtCh == 2'(i)) begin
            tone_d[i] = isLatch ? {tone_q[i][9:4], bus.wr_data[3:0]}
                                : {bus.wr_data[5:0], tone_q[i][3:0]};
          end
        end
      end
    end
  end

  // State and configuration registers; reset leaves the chip silent and idle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      latchCh_q   <= 2'd0;
      latchType_q <= 1'b0;
      noiseCtrl_q <= 3'd0;
      noiseRst_q  <= 1'b0;
      for (int i = 0; i < 3; i++) tone_q[i] <= 10'd0;
      for (int i = 0; i < 4; i++) vol_q[i] <= 4'hF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      latchCh_q   <= latchCh_d;
      latchType_q <= latchType_d;
      noiseCtrl_q <= noiseCtrl_d;
      noiseRst_q  <= noiseRst_d;
      for (int i = 0; i < 3; i++) tone_q[i] <= tone_d[i];
      for (int i = 0; i < 4; i++) vol_q[i] <= vol_d[i];
    end
  end

  assign bus.wr_ready   = (state_q == IDLE);
  assign bus.tone0      = tone_q[0];
  assign bus.tone1      = tone_q[1];
  assign bus.tone2      = tone_q[2];
  assign bus.noise_ctrl = noiseCtrl_q;
  assign bus.noise_rst  = noiseRst_q;
  assign bus.vol0       = vol_q[0];
  assign bus.vol1       = vol_q[1];
  assign bus.vol2       = vol_q[2];
  assign bus.vol3       = vol_q[3];

endmodule

// File: tb/tb_ti_reg_ctrl.sv
// Directed bench for ti_reg_ctrl: one instance with the default busy window,
// one with no busy window, driven through their interfaces.
module tb_ti_reg_ctrl;

  logic CLK = 1'b0;
  logic nRstA;
  logic nRstB;

  int vecCount = 0;
  int errCount = 0;

  ti_reg_ctrl_if ifA ();
  ti_reg_ctrl_if ifB ();

  ti_reg_ctrl #(.WAIT_CYCLES(32)) dutA (.CLK(CLK), .nRST(nRstA), .bus(ifA));
  ti_reg_ctrl #(.WAIT_CYCLES(0))  dutB (.CLK(CLK), .nRST(nRstB), .bus(ifB));

  // Free-running clock shared by both instances.
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for instance A to become ready, sampling on falling edges.
  task automatic waitReadyA(input string tag);
    int n = 0;
    while (!ifA.wr_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!ifA.wr_ready) checkOutput(tag, 16'(ifA.wr_ready), 16'd1);
  endtask

  // Present one byte to instance A, hold it until accepted, return one cycle later.
  task automatic applyStimulus(input logic [7:0] b);
    waitReadyA("ready_timeout");
    ifA.wr_valid = 1'b1;
    ifA.wr_data  = b;
    @(posedge CLK);
    @(negedge CLK);
    ifA.wr_valid = 1'b0;
  endtask

  initial begin
    int  n;
    bit  holdOk;

    nRstA = 1'b0;
    nRstB = 1'b0;
    ifA.wr_valid = 1'b0;
    ifA.wr_data  = 8'h00;
    ifB.wr_valid = 1'b0;
    ifB.wr_data  = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRstA = 1'b1;
    nRstB = 1'b1;

    // Reset state
    checkOutput("rst_tone0", 16'(ifA.tone0), 16'h000);
    checkOutput("rst_tone1", 16'(ifA.tone1), 16'h000);
    checkOutput("rst_tone2", 16'(ifA.tone2), 16'h000);
    checkOutput("rst_noise", 16'(ifA.noise_ctrl), 16'h0);
    checkOutput("rst_nrst",  16'(ifA.noise_rst), 16'h0);
    checkOutput("rst_vols",  {ifA.vol0, ifA.vol1, ifA.vol2, ifA.vol3}, 16'hFFFF);
    checkOutput("rst_ready", 16'(ifA.wr_ready), 16'h1);

    // Test 1: volume latch and busy window length
    applyStimulus(8'h9A);
    checkOutput("t1_vol0",  16'(ifA.vol0), 16'hA);
    checkOutput("t1_other_vols", {4'h0, ifA.vol1, ifA.vol2, ifA.vol3}, 16'h0FFF);
    checkOutput("t1_tone0", 16'(ifA.tone0), 16'h000);
    checkOutput("t1_noise", 16'(ifA.noise_ctrl), 16'h0);
    n = 0;
    while (!ifA.wr_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("t1_busy_len", 16'(n), 16'd32);

    // Test 2: tone latch low nibble, then data byte upper six bits
    applyStimulus(8'h8E);
    checkOutput("t2_tone0_lo", 16'(ifA.tone0), 16'h00E);
    applyStimulus(8'h0F);
    checkOutput("t2_tone0", 16'(ifA.tone0), 16'h0FE);
    checkOutput("t2_tone1", 16'(ifA.tone1), 16'h000);
    checkOutput("t2_tone2", 16'(ifA.tone2), 16'h000);

    // Test 3: noise latch and data writes each pulse noise_rst for one cycle
    applyStimulus(8'hE5);
    checkOutput("t3_noise", 16'(ifA.noise_ctrl), 16'h5);
    checkOutput("t3_pulse", 16'(ifA.noise_rst), 16'h1);
    @(negedge CLK);
    checkOutput("t3_pulse_end", 16'(ifA.noise_rst), 16'h0);
    applyStimulus(8'h43);
    checkOutput("t3_noise2", 16'(ifA.noise_ctrl), 16'h3);
    checkOutput("t3_pulse2", 16'(ifA.noise_rst), 16'h1);
    @(negedge CLK);
    checkOutput("t3_pulse2_end", 16'(ifA.noise_rst), 16'h0);
    checkOutput("t3_tone0_kept", 16'(ifA.tone0), 16'h0FE);

    // Test 4: a byte held during BUSY is taken only on the first ready cycle
    applyStimulus(8'hB3);
    applyStimulus(8'hD5);
    checkOutput("t4_vol2_pre", 16'(ifA.vol2), 16'h5);
    applyStimulus(8'hDF);
    checkOutput("t4_vol2", 16'(ifA.vol2), 16'hF);
    ifA.wr_valid = 1'b1;
    ifA.wr_data  = 8'hBF;
    n = 0;
    holdOk = 1'b1;
    while (!ifA.wr_ready && n < 200) begin
      if (ifA.vol1 != 4'h3) holdOk = 1'b0;
      @(negedge CLK);
      n++;
    end
    checkOutput("t4_busy_len", 16'(n), 16'd32);
    checkOutput("t4_vol1_held", 16'(holdOk), 16'h1);
    checkOutput("t4_vol1_at_ready", 16'(ifA.vol1), 16'h3);
    @(posedge CLK);
    @(negedge CLK);
    ifA.wr_valid = 1'b0;
    checkOutput("t4_vol1", 16'(ifA.vol1), 16'hF);
    checkOutput("t4_ready_low", 16'(ifA.wr_ready), 16'h0);

    // Test 5: reset in the middle of BUSY, then a data byte hits channel 0 tone
    waitReadyA("t5_ready_timeout");
    applyStimulus(8'h90);
    checkOutput("t5_vol0", 16'(ifA.vol0), 16'h0);
    repeat (3) @(negedge CLK);
    nRstA = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nRstA = 1'b1;
    checkOutput("t5_vol0_rst", 16'(ifA.vol0), 16'hF);
    checkOutput("t5_ready_rst", 16'(ifA.wr_ready), 16'h1);
    checkOutput("t5_tone0_rst", 16'(ifA.tone0), 16'h000);
    applyStimulus(8'h3F);
    checkOutput("t5_tone0", 16'(ifA.tone0), 16'h3F0);
    checkOutput("t5_noise", 16'(ifA.noise_ctrl), 16'h0);

    // Test 6: zero busy window, always ready, back-to-back writes
    checkOutput("t6_ready_rst", 16'(ifB.wr_ready), 16'h1);
    ifB.wr_valid = 1'b1;
    ifB.wr_data  = 8'h9A;
    @(posedge CLK);
    @(negedge CLK);
    ifB.wr_valid = 1'b0;
    checkOutput("t6_vol0", 16'(ifB.vol0), 16'hA);
    checkOutput("t6_ready", 16'(ifB.wr_ready), 16'h1);
    ifB.wr_valid = 1'b1;
    ifB.wr_data  = 8'hA4;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t6_ready_b2b", 16'(ifB.wr_ready), 16'h1);
    checkOutput("t6_tone1_lo", 16'(ifB.tone1), 16'h004);
    ifB.wr_data = 8'h12;
    @(posedge CLK);
    @(negedge CLK);
    ifB.wr_valid = 1'b0;
    checkOutput("t6_tone1", 16'(ifB.tone1), 16'h124);
    checkOutput("t6_tone0", 16'(ifB.tone0), 16'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/ti_reg_ctrl.md
Name: ti_reg_ctrl

Overview:
Register-write controller for the TI SN76489-style PSG.
- Accepts CPU byte writes in the chip's latch/data format over a valid/ready handshake.
- Decodes each byte and holds the configuration that drives the tone generators, the noise generator and the ti_mixer volume inputs (vol0..vol3).
- Models the chip's write-busy window: after each accepted byte, further writes are stalled for a fixed number of cycles.

Parameters:
- WAIT_CYCLES, 32: cycles wr_ready stays low after each accepted byte. 0 means always ready.
- BUSY_W, $clog2(WAIT_CYCLES+1): busy counter width. Derived; do not override.

Ports:
- CLK  input  1  system clock; all state changes on posedge
- nRST  input  1  synchronous active-low reset, sampled on posedge CLK
- wr_valid  input  1  CPU presents a byte
- wr_data  input  8  CPU byte, latch or data format
- wr_ready  output  1  controller can accept a byte this cycle
- tone0, tone1, tone2  output  10 each  tone period registers, channels 0-2
- noise_ctrl  output  3  bit2 = feedback mode (1 white, 0 periodic); [1:0] = shift rate select
- noise_rst  output  1  one-cycle pulse; resets the noise LFSR
- vol0, vol1, vol2, vol3  output  4 each  attenuation to ti_mixer (0 loudest, 0xF off)

Behaviour:
- Reset (nRST low at posedge):
  - tone0..2 = 0, noise_ctrl = 0, noise_rst = 0.
  - vol0..3 = 4'hF (silent).
  - Latch register (latch_ch, latch_type) = {0, 0}, i.e. channel 0 tone.
  - Busy counter = 0, FSM = IDLE, wr_ready = 1.
  - Reset overrides any operation in progress, including mid-busy.
- Handshake: a byte is accepted on the posedge where wr_valid && wr_ready. wr_data need only be stable that cycle.
- FSM has two states:
  - IDLE: wr_ready = 1. On accept, go to BUSY with counter = WAIT_CYCLES. If WAIT_CYCLES = 0, stay in IDLE.
  - BUSY: wr_ready = 0. Counter decrements each cycle; when counter == 1, next state is IDLE.
  - Net timing: accept at edge t; wr_ready is low for exactly WAIT_CYCLES cycles after t and high again in cycle t+WAIT_CYCLES+1.
  - wr_valid asserted while BUSY is ignored. The byte is not queued; the CPU must hold it until wr_ready.
- wr_ready is a registered output (a function of FSM state), never combinational from wr_valid.
- Latch byte (wr_data[7] = 1):
  - latch_ch = d[6:5], latch_type = d[4] (1 = volume, 0 = tone/noise).
  - Volume: vol[latch_ch] = d[3:0].
  - Tone, latch_ch 0-2: tone[latch_ch][3:0] = d[3:0]; upper 6 bits kept.
  - Tone, latch_ch 3: noise_ctrl = d[2:0]; d[3] ignored; noise_rst pulses.
- Data byte (wr_data[7] = 0): uses the stored latch register.
  - Volume: vol[latch_ch] = d[3:0].
  - Tone, ch 0-2: tone[latch_ch][9:4] = d[5:0]; lower 4 bits kept.
  - Tone, ch 3: noise_ctrl = d[2:0]; noise_rst pulses.
  - d[6] is ignored.
- Latency:
  - Register updates are visible in the cycle after the accepting edge (1-cycle latency).
  - noise_rst is high for exactly that one cycle, aligned with the new noise_ctrl value.
  - Writing an identical noise value still pulses noise_rst.
- Data byte before any latch since reset targets ch0 tone, per the reset latch value.
- Every write to noise_ctrl pulses noise_rst. No other register write affects noise_rst.
- Only the addressed register changes; all others hold.

Test Plan:
1. Reset, then write 0x9A (WAIT_CYCLES = 32) -> next cycle vol0 = 0xA, all else at reset values; wr_ready low 32 cycles, high on the 33rd.
2. Write 0x8E, wait for ready, write 0x0F -> tone0 = 0x00E after first byte, 0x0FE after second; tone1/2 stay 0.
3. Write 0xE5 -> noise_ctrl = 5, noise_rst high exactly 1 cycle. Then data byte 0x43 -> noise_ctrl = 3, second 1-cycle pulse.
4. Hold wr_valid with 0xBF during BUSY after a 0xDF write -> vol2 = 0xF, vol1 unchanged until ready; 0xBF accepted on the first ready cycle, vol1 = 0xF next cycle.
5. Reset mid-BUSY after write 0x90 -> vol0 returns to 0xF and wr_ready = 1 in the cycle after reset. Then data byte 0x3F -> tone0 = 0x3F0.
6. Repeat test 1 with WAIT_CYCLES = 0 -> wr_ready constantly 1. Back-to-back 0xA4, 0x12 -> tone1 = 0x124 two cycles after the first accept.
